mk14_display_scan: RTL and testbench

Multiplexed 8-digit 7-segment driver for the MK14 SoC on iCE40 boards. It consumes the SoC's 64-bit `display` image (8 digits × 8 segment bits) and drives physical digit strobes and segment lines one digit at a time. Each digit gets an inter-digit blanking gap against ghosting and 16-level PWM brightness. The display image is snapshotted once per frame so the visible frame never tears while the CPU updates it. It sits in the board top level between `mk14_soc` and the package pins.

---
 rtl/mk14_display_scan.sv | 96 +++++++++
 tb/tb_mk14_display_scan.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mk14_display_scan.sv
// Multiplexed 8-digit 7-segment scanner with inter-digit blanking, 16-level PWM
// and a per-frame snapshot of the display image so a frame never tears.
module mk14_display_scan #(
  parameter int CLOCK_FREQ_MHZ = 12,
  parameter int DIGIT_US       = 1000,
  parameter int BLANK_CYCLES   = 16,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic        CLK,
  input  logic        rst_n,
  input  logic [63:0] display,
  input  logic [3:0]  brightness,
  output logic [7:0]  seg,
  output logic [7:0]  dig,
  output logic        frame_start
);

  localparam int DIGIT_CYCLES = CLOCK_FREQ_MHZ * DIGIT_US;
  localparam int DW           = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;

  localparam logic [DW-1:0] DWELL_LAST = DW'(DIGIT_CYCLES - 1);
  localparam logic [DW-1:0] DWELL_ON   = DW'(BLANK_CYCLES);
  localparam logic [DW-1:0] DWELL_ONE  = DW'(1);

  // Idle patterns double as XOR masks that apply the output polarity.
  localparam logic [7:0] SEG_IDLE = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [7:0] DIG_IDLE = (DIG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_ON    = 1'b1;

  logic [DW-1:0] dwell;
  logic [2:0]    digit;
  logic [3:0]    pwm;
  logic [63:0]   snap;
  logic [3:0]    bright_q;

  logic [0:0]    state;
  logic          frame_edge;
  logic [7:0]    dig_sel;
  logic [7:0]    seg_lit;

  // The counter state (0,0) is exactly the start of a frame, whether reached by
  // the 7->0 wrap or by coming out of reset, so it drives the snapshot.
  always_comb begin
    state      = (dwell >= DWELL_ON) ? ST_ON : ST_BLANK;
    frame_edge = (dwell == '0) && (digit == 3'd0);
    dig_sel    = 8'd1 << digit;
    seg_lit    = (pwm <= bright_q) ? snap[{digit, 3'b000} +: 8] : 8'h00;
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      dwell <= '0;
      digit <= 3'd0;
      pwm   <= 4'd0;
    end else begin
      pwm <= pwm + 4'd1;
      if (dwell == DWELL_LAST) begin
        dwell <= '0;
        digit <= digit + 3'd1;
      end else begin
        dwell <= dwell + DWELL_ONE;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      snap        <= 64'd0;
      bright_q    <= 4'd0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_edge;
      if (frame_edge) begin
        snap     <= display;
        bright_q <= brightness;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      seg <= SEG_IDLE;
      dig <= DIG_IDLE;
    end else if (state == ST_ON) begin
      seg <= seg_lit ^ SEG_IDLE;
      dig <= dig_sel ^ DIG_IDLE;
    end else begin
      seg <= SEG_IDLE;
      dig <= DIG_IDLE;
    end
  end

endmodule

// File: tb/tb_mk14_display_scan.sv
// Scoreboard bench for mk14_display_scan: a frame-position reference model
// queues expected outputs, a monitor pops and compares every cycle.
module tb_mk14_display_scan;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic [63:0] display;
  logic [3:0]  brightness;
  logic [7:0]  seg;
  logic [7:0]  dig;
  logic        frame_start;

  typedef struct packed {
    logic [7:0] seg;
    logic [7:0] dig;
    logic       fs;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails = 0;
  int   tcount = 0;
  bit   model_live = 1'b0;

  always #5 CLK = ~CLK;

  mk14_display_scan #(
    .CLOCK_FREQ_MHZ(1),
    .DIGIT_US(8),
    .BLANK_CYCLES(2),
    .SEG_ACTIVE_LOW(1),
    .DIG_ACTIVE_LOW(1)
  ) dut (
    .CLK(CLK),
    .rst_n(rst_n),
    .display(display),
    .brightness(brightness),
    .seg(seg),
    .dig(dig),
    .frame_start(frame_start)
  );

  // Reference: position in a 64-cycle frame counted from reset release.
  initial begin : model
    exp_t        e;
    logic [63:0] frame_img;
    logic [3:0]  frame_bri;
    int          p, k, d;
    frame_img = '0;
    frame_bri = '0;
    forever begin
      @(posedge CLK);
      if (!rst_n) begin
        model_live = 1'b1;
        tcount = 0;
        e = '{seg: 8'hFF, dig: 8'hFF, fs: 1'b0};
        exp_q.push_back(e);
      end else if (model_live) begin
        p = tcount % 64;
        k = p / 8;
        d = p % 8;
        if (p == 0) begin
          frame_img = display;
          frame_bri = brightness;
        end
        e.fs = (p == 0);
        if (d < 2) begin
          e.seg = 8'hFF;
          e.dig = 8'hFF;
        end else begin
          e.dig = ~(8'd1 << k);
          e.seg = ((tcount % 16) <= int'(frame_bri)) ? ~frame_img[k*8 +: 8] : 8'hFF;
        end
        exp_q.push_back(e);
        tcount = tcount + 1;
      end
    end
  end

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %h, required %h", name, $time, act, req);
    end
  endtask

  // Monitor: scoreboard compare plus strobe non-overlap and blanking-gap rules.
  initial begin : monitor
    exp_t e;
    int   gap;
    bit   prev_active;
    gap = 0;
    prev_active = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("seg", seg, e.seg);
        check_output("dig", dig, e.dig);
        check_output("frame_start", {7'd0, frame_start}, {7'd0, e.fs});
      end
      if (model_live) begin
        check_output("dig_onehot", 8'($countones(~dig) > 1), 8'd0);
        if (dig != 8'hFF) begin
          if (!prev_active) check_output("blank_gap_ok", 8'(gap >= 2), 8'd1);
          prev_active = 1'b1;
          gap = 0;
        end else begin
          prev_active = 1'b0;
          gap++;
        end
      end
    end
  end

  task automatic apply_stimulus(input logic [63:0] img, input logic [3:0] bri);
    display    = img;
    brightness = bri;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Waits until the next edge lands on frame position p; bounded.
  task automatic wait_pos(input int p);
    int budget;
    budget = 0;
    while (!(rst_n && (tcount % 64) == p) && budget < 200) begin
      @(negedge CLK);
      budget++;
    end
    check_output("wait_pos_timeout", 8'(budget >= 200), 8'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    rst_n = 1'b0;
    apply_stimulus('1, 4'd0);
    run_cycles(5);

    $display("[TB] scan order");
    apply_stimulus(64'h0706050403020100, 4'd15);
    rst_n = 1'b1;
    run_cycles(130);

    $display("[TB] tear-free snapshot");
    wait_pos(28);
    apply_stimulus('1, 4'd15);
    run_cycles(80);

    $display("[TB] brightness 3");
    wait_pos(60);
    apply_stimulus('1, 4'd3);
    run_cycles(140);

    $display("[TB] mid-operation reset");
    wait_pos(44);
    rst_n = 1'b0;
    run_cycles(1);
    rst_n = 1'b1;
    run_cycles(80);

    $display("[TB] random frames");
    for (int i = 0; i < 640; i++) begin
      if ($urandom_range(0, 15) == 0)
        apply_stimulus({$urandom, $urandom}, 4'($urandom_range(0, 15)));
      run_cycles(1);
    end
    run_cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
